// File: rtl/ppu_vram_arbiter_if.sv
// Bundles the fetch, CPU and VRAM sides of the PPU VRAM arbiter.
// The slave modport is the arbiter; the master modport is whatever drives it.
interface ppu_vram_arbiter_if;
   logic        vblank;
   logic        render_en;

   logic        fetch_req;
   logic [13:0] fetch_addr;
   logic        fetch_valid;
   logic [7:0]  fetch_rdata;

   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic [7:0]  cpu_rdata;

   logic [13:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata;

   modport slave (
      input  vblank, render_en,
      input  fetch_req, fetch_addr,
      output fetch_valid, fetch_rdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_busy, cpu_done, cpu_rdata,
      output vram_addr, vram_we, vram_wdata,
      input  vram_rdata
   );

   modport master (
      output vblank, render_en,
      output fetch_req, fetch_addr,
      input  fetch_valid, fetch_rdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_busy, cpu_done, cpu_rdata,
      input  vram_addr, vram_we, vram_wdata,
      output vram_rdata
   );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM bus arbiter: fetch sequencer vs. one-deep CPU buffer; PPU_ARB_STARVE_EN adds a CPU starvation guard.
// Fetch: req->valid in 2 cycles; CPU: req->done in 3 uncontended; a cpu_req arriving while busy is dropped.
module ppu_vram_arbiter #(
   parameter int MAX_WAIT = 8
) (
   input logic               clk,
   input logic               reset,
   ppu_vram_arbiter_if.slave bus
);

   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
      $error("ppu_vram_arbiter: MAX_WAIT must be within 1..255");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        cur_cpu;

   logic        buf_vld;
   logic        buf_we;
   logic [13:0] buf_addr;
   logic [7:0]  buf_wdata;

   logic [7:0]  fetch_rdata_q;
   logic [7:0]  cpu_rdata_q;

   logic        rendering;
   logic        buf_pending;
   logic        starve;
   logic        grant_fetch;
   logic        grant_cpu;

   // The buffer still holds the CPU access during its own COMPLETE cycle;
   // it must not be arbitrated a second time there.
   assign rendering   = bus.render_en & ~bus.vblank;
   assign buf_pending = buf_vld & ~((state == COMPLETE) & cur_cpu);

`ifdef PPU_ARB_STARVE_EN
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (grant_cpu) begin
         wait_cnt <= '0;
      end else if (buf_pending && !((state == ACCESS) && cur_cpu) && (wait_cnt != 8'hFF)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign starve = (wait_cnt >= MAX_WAIT_C);
`else
   assign starve = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      grant_fetch = 1'b0;
      grant_cpu   = 1'b0;
      case (state)
         IDLE, COMPLETE: begin
            if (rendering && bus.fetch_req && !(buf_pending && starve)) begin
               grant_fetch = 1'b1;
            end else if (buf_pending) begin
               grant_cpu = 1'b1;
            end else if (bus.fetch_req) begin
               grant_fetch = 1'b1;
            end
            state_nxt = (grant_fetch || grant_cpu) ? ACCESS : IDLE;
         end
         ACCESS: begin
            state_nxt = COMPLETE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cur_cpu        <= 1'b0;
         bus.vram_addr  <= '0;
         bus.vram_we    <= 1'b0;
         bus.vram_wdata <= '0;
         fetch_rdata_q  <= '0;
         cpu_rdata_q    <= '0;
      end else begin
         state       <= state_nxt;
         bus.vram_we <= 1'b0;

         if (grant_fetch) begin
            cur_cpu       <= 1'b0;
            bus.vram_addr <= bus.fetch_addr;
         end else if (grant_cpu) begin
            cur_cpu       <= 1'b1;
            bus.vram_addr <= buf_addr;
            bus.vram_we   <= buf_we;
            if (buf_we) begin
               bus.vram_wdata <= buf_wdata;
            end
         end

         if (state == COMPLETE) begin
            if (!cur_cpu) begin
               fetch_rdata_q <= bus.vram_rdata;
            end else if (!buf_we) begin
               cpu_rdata_q <= bus.vram_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_vld   <= 1'b0;
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= '0;
      end else if ((state == COMPLETE) && cur_cpu) begin
         buf_vld <= 1'b0;
      end else if (!buf_vld && bus.cpu_req) begin
         buf_vld   <= 1'b1;
         buf_we    <= bus.cpu_we;
         buf_addr  <= bus.cpu_addr;
         buf_wdata <= bus.cpu_wdata;
      end
   end

   // Read data appears on the bus in COMPLETE straight from VRAM, then is held.
   assign bus.fetch_valid = (state == COMPLETE) & ~cur_cpu;
   assign bus.cpu_done    = (state == COMPLETE) & cur_cpu;
   assign bus.fetch_rdata = bus.fetch_valid ? bus.vram_rdata : fetch_rdata_q;
   assign bus.cpu_rdata   = (bus.cpu_done && !buf_we) ? bus.vram_rdata : cpu_rdata_q;
   assign bus.cpu_busy    = buf_vld;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with a VRAM model and a CPU-access scoreboard.
// Works in both builds; contention expectations follow PPU_ARB_STARVE_EN.
module tb_ppu_vram_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   ppu_vram_arbiter_if bus ();

   ppu_vram_arbiter #(.MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t cpu_q[$];
   int   errors = 0;
   int   checks = 0;
   int   fetch_cnt = 0;
   int   done_cnt = 0;
   int   we_cnt = 0;

   logic [7:0] mem [0:16383];

   function automatic logic [7:0] pat(input logic [13:0] a);
      return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic cpu_drive(input logic we, input logic [13:0] addr, input logic [7:0] wd);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
   endtask

   // VRAM model: synchronous read, data one cycle after the address.
   always @(posedge clk) begin
      bus.vram_rdata <= mem[bus.vram_addr];
      if (bus.vram_we) mem[bus.vram_addr] = bus.vram_wdata;
   end

   // Scoreboard / monitor on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.fetch_valid) begin
            fetch_cnt++;
            check("fetch_rdata", 32'(bus.fetch_rdata), 32'(pat(bus.fetch_addr)));
         end
         if (bus.fetch_valid || bus.cpu_done)
            check("pulse_overlap", 32'(bus.fetch_valid & bus.cpu_done), 32'd0);
         if (bus.vram_we) begin
            we_cnt++;
            check("we_expected", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
               check("we_is_write", 32'(cpu_q[0].we), 32'd1);
               check("we_addr", 32'(bus.vram_addr), 32'(cpu_q[0].addr));
               check("we_data", 32'(bus.vram_wdata), 32'(cpu_q[0].data));
            end
         end
         if (bus.cpu_done) begin
            done_cnt++;
            check("done_expected", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
               exp_t e;
               e = cpu_q.pop_front();
               if (!e.we) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_done;
      int base_we;
      int base_fetch;
      bit got;
      bit busy_ok;
      bit done_seen;
      exp_t e;

      for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
      mem[14'h23C0] = 8'h3C;

      bus.vblank     = 1'b0;
      bus.render_en  = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 14'h0123;
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;

      // Reset held 2 cycles with fetch_req asserted
      @(posedge clk);
      @(posedge clk);
      nxt();
      check("rst_state", 32'(dut.state), 32'd0);
      check("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
      check("rst_vram_we", 32'(bus.vram_we), 32'd0);
      check("rst_vram_wdata", 32'(bus.vram_wdata), 32'd0);
      check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      check("rst_fetch_rdata", 32'(bus.fetch_rdata), 32'd0);
      check("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
      check("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      reset = 1'b0;                                   // cycle 0
      nxt();                                          // cycle 1
      check("fetch1_valid_c1", 32'(bus.fetch_valid), 32'd0);
      check("fetch1_addr_c1", 32'(bus.vram_addr), 32'h0123);
      nxt();                                          // cycle 2
      check("fetch1_valid_c2", 32'(bus.fetch_valid), 32'd1);
      nxt();
      check("fetch2_valid_c3", 32'(bus.fetch_valid), 32'd0);
      nxt();
      check("fetch2_valid_c4", 32'(bus.fetch_valid), 32'd1);
      bus.fetch_req = 1'b0;
      nxt();
      nxt();
      check("fetch_count_b2b", 32'(fetch_cnt), 32'd2);

      // Vblank CPU write
      bus.vblank = 1'b1;
      nxt();
      check("wr_busy_c0", 32'(bus.cpu_busy), 32'd0);
      cpu_drive(1'b1, 14'h2000, 8'h5A);
      e.we = 1'b1; e.addr = 14'h2000; e.data = 8'h5A;
      cpu_q.push_back(e);
      nxt();
      bus.cpu_req = 1'b0;
      check("wr_busy_c1", 32'(bus.cpu_busy), 32'd1);
      check("wr_we_c1", 32'(bus.vram_we), 32'd0);
      nxt();
      check("wr_we_c2", 32'(bus.vram_we), 32'd1);
      check("wr_addr_c2", 32'(bus.vram_addr), 32'h2000);
      check("wr_data_c2", 32'(bus.vram_wdata), 32'h5A);
      check("wr_done_c2", 32'(bus.cpu_done), 32'd0);
      nxt();
      check("wr_done_c3", 32'(bus.cpu_done), 32'd1);
      check("wr_we_c3", 32'(bus.vram_we), 32'd0);
      nxt();
      check("wr_busy_c4", 32'(bus.cpu_busy), 32'd0);
      check("wr_mem", 32'(mem[14'h2000]), 32'h5A);

      // Vblank CPU read
      nxt();
      cpu_drive(1'b0, 14'h23C0, 8'h00);
      e.we = 1'b0; e.addr = 14'h23C0; e.data = 8'h3C;
      cpu_q.push_back(e);
      nxt();
      bus.cpu_req = 1'b0;
      nxt();
      check("rd_addr_c2", 32'(bus.vram_addr), 32'h23C0);
      check("rd_we_c2", 32'(bus.vram_we), 32'd0);
      nxt();
      check("rd_done_c3", 32'(bus.cpu_done), 32'd1);
      check("rd_data_c3", 32'(bus.cpu_rdata), 32'h3C);
      repeat (3) nxt();
      check("rd_done_after", 32'(bus.cpu_done), 32'd0);
      check("rd_data_hold", 32'(bus.cpu_rdata), 32'h3C);

      // Dropped request while busy
      base_done = done_cnt;
      base_we   = we_cnt;
      cpu_drive(1'b1, 14'h2100, 8'h11);
      e.we = 1'b1; e.addr = 14'h2100; e.data = 8'h11;
      cpu_q.push_back(e);
      nxt();
      check("drop_busy", 32'(bus.cpu_busy), 32'd1);
      cpu_drive(1'b1, 14'h2100, 8'hFF);
      nxt();
      bus.cpu_req = 1'b0;
      repeat (6) nxt();
      check("drop_we_count", 32'(we_cnt - base_we), 32'd1);
      check("drop_done_count", 32'(done_cnt - base_done), 32'd1);
      check("drop_mem", 32'(mem[14'h2100]), 32'h11);
      check("drop_busy_end", 32'(bus.cpu_busy), 32'd0);

      // Contention: rendering with fetch_req held continuously
      bus.vblank    = 1'b0;
      bus.render_en = 1'b1;
      bus.fetch_req = 1'b1;
      repeat (3) nxt();
      base_done  = done_cnt;
      base_fetch = fetch_cnt;
      cpu_drive(1'b0, 14'h0010, 8'h00);
      e.we = 1'b0; e.addr = 14'h0010; e.data = pat(14'h0010);
      cpu_q.push_back(e);
      nxt();
      bus.cpu_req = 1'b0;
`ifdef PPU_ARB_STARVE_EN
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done_cnt != base_done) begin
            got = 1'b1;
            break;
         end
         nxt();
      end
      check("starve_done", 32'(got), 32'd1);
      check("starve_fetch_slots", 32'((fetch_cnt - base_fetch) <= 7), 32'd1);
      check("starve_fetch_progress", 32'((fetch_cnt - base_fetch) >= 1), 32'd1);
      bus.fetch_req = 1'b0;
      repeat (4) nxt();
`else
      busy_ok   = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!bus.cpu_busy) busy_ok = 1'b0;
         if (bus.cpu_done) done_seen = 1'b1;
         nxt();
      end
      check("hold_busy", 32'(busy_ok), 32'd1);
      check("hold_no_done", 32'(done_seen), 32'd0);
      check("hold_fetch_progress", 32'((fetch_cnt - base_fetch) >= 10), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.fetch_valid) begin
            got = 1'b1;
            break;
         end
         nxt();
      end
      check("hold_find_valid", 32'(got), 32'd1);
      nxt();
      bus.fetch_req = 1'b0;                           // d0
      nxt();
      check("release_done_d1", 32'(bus.cpu_done), 32'd0);
      nxt();
      check("release_done_d2", 32'(bus.cpu_done), 32'd0);
      nxt();
      check("release_done_d3", 32'(bus.cpu_done), 32'd1);
      nxt();
      check("release_busy_d4", 32'(bus.cpu_busy), 32'd0);
`endif
      check("contention_queue_empty", 32'(cpu_q.size()), 32'd0);

      // Reset in the middle of a CPU write
      bus.vblank = 1'b1;
      nxt();
      cpu_drive(1'b1, 14'h2200, 8'h77);
      e.we = 1'b1; e.addr = 14'h2200; e.data = 8'h77;
      cpu_q.push_back(e);
      nxt();
      bus.cpu_req = 1'b0;
      nxt();
      check("mid_we_c2", 32'(bus.vram_we), 32'd1);
      #1;
      reset = 1'b1;
      cpu_q.delete();
      base_done = done_cnt;
      nxt();
      check("mid_done", 32'(bus.cpu_done), 32'd0);
      check("mid_busy", 32'(bus.cpu_busy), 32'd0);
      check("mid_state", 32'(dut.state), 32'd0);
      check("mid_vram_addr", 32'(bus.vram_addr), 32'd0);
      nxt();
      #1;
      reset = 1'b0;
      repeat (4) nxt();
      check("mid_no_done_after", 32'(done_cnt - base_done), 32'd0);
      check("mid_busy_after", 32'(bus.cpu_busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Arbiter and sequencer for the PPU's single-ported VRAM bus. It sits between the PPU background/sprite fetch sequencer and the CPU-facing PPUDATA ($2007) register path, and owns all VRAM address, write-enable and write-data signals. The PPU fetch sequencer has priority while rendering. CPU accesses are buffered one deep and issued in fetch gaps or during vblank, with an optional starvation guard.

## Interface
- MAX_WAIT, default 8: number of cycles a pending CPU access may wait before the starvation guard forces it. Range 1–255.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- vblank  in  1  high during vertical blank.
- render_en  in  1  rendering enabled (PPUMASK bg|sprite).
- fetch_req  in  1  fetch sequencer requests a read; held until fetch_valid.
- fetch_addr  in  14  fetch read address; stable while fetch_req is high.
- fetch_valid  out  1  one-cycle pulse; fetch_rdata is valid.
- fetch_rdata  out  8  fetch read data.
- cpu_req  in  1  one-cycle pulse from the PPUDATA path.
- cpu_we  in  1  qualifies cpu_req: 1 = write, 0 = read.
- cpu_addr  in  14  CPU VRAM address (v register).
- cpu_wdata  in  8  CPU write data.
- cpu_busy  out  1  a CPU access is pending or in flight.
- cpu_done  out  1  one-cycle pulse when a CPU access completes.
- cpu_rdata  out  8  CPU read data, held until the next CPU read completes.
- vram_addr  out  14  VRAM address (registered).
- vram_we  out  1  VRAM write strobe (registered).
- vram_wdata  out  8  VRAM write data (registered).
- vram_rdata  in  8  VRAM read data; valid one cycle after the address is presented.

## Operation
- CPU buffer:
  - One-deep buffer holding we/addr/wdata. It captures on cpu_req when empty; cpu_busy rises the next cycle.
  - cpu_req while cpu_busy = 1 is dropped silently; the buffer is unchanged.
  - The buffer clears on the cycle cpu_done pulses.
- States:
  - IDLE: bus idle; vram_we = 0, vram_addr holds its last value.
  - ACCESS: address, and for writes the write data plus vram_we, driven to VRAM.
  - COMPLETE: vram_rdata captured; the valid/done pulse is issued.
- Arbitration, evaluated in IDLE and COMPLETE:
  - rendering = render_en & ~vblank.
  - If rendering and fetch_req, the fetch wins, unless the starvation guard fires.
  - Otherwise a pending CPU access wins.
  - Otherwise a non-rendering fetch_req wins.
  - Otherwise go to IDLE.
- Transitions:
  - IDLE → ACCESS when there is a winner.
  - ACCESS → COMPLETE always.
  - COMPLETE → ACCESS when there is a winner, otherwise IDLE.
- A fetch is never pre-empted once in ACCESS.
- fetch_req dropping while its access is in ACCESS still yields the fetch_valid pulse, which the sequencer ignores.
- CPU writes also pass through COMPLETE, with vram_we = 0 there. cpu_rdata is updated only for reads.
- Simultaneous cpu_req and a winning fetch: the CPU request is buffered and the fetch proceeds.
- Reset mid-operation: any in-flight access is abandoned, the buffer is cleared, and no valid/done pulse is issued.

## Timing
- Reset values: state IDLE, vram_addr 0, vram_we 0, vram_wdata 0, fetch_valid 0, fetch_rdata 0, cpu_busy 0, cpu_done 0, cpu_rdata 0, wait counter 0.
- Fetch latency: fetch_req seen in cycle N (arbiter in IDLE) → vram_addr driven in N+1 → fetch_valid with data in N+2.
- Back-to-back fetches sustain one access per 2 cycles.
- CPU latency, uncontended: cpu_req in cycle N → buffered and cpu_busy = 1 in N+1 → ACCESS in N+2 → cpu_done in N+3.
- vram_we is high for exactly one cycle per CPU write, in ACCESS only.
- cpu_done and fetch_valid are never high in the same cycle.

## Configuration
- PPU_ARB_STARVE_EN defined:
  - An 8-bit wait counter increments each cycle the buffer is full and the CPU loses arbitration; it saturates at 255.
  - When count ≥ MAX_WAIT, the CPU wins the next decision regardless of fetch_req.
  - The counter clears when the CPU access enters ACCESS.
- PPU_ARB_STARVE_EN undefined:
  - No counter.
  - While rendering, the CPU is served only in cycles with fetch_req = 0.

## Test plan
- Reset: hold reset 2 cycles with fetch_req = 1 → all outputs at reset values, state IDLE; first fetch_valid 2 cycles after reset deasserts.
- Vblank CPU write: vblank = 1, cpu_req/cpu_we = 1, addr 0x2000, data 0x5A in cycle 0 → vram_we = 1 with addr 0x2000/data 0x5A in cycle 2, cpu_done in cycle 3, cpu_busy low in cycle 4.
- Vblank CPU read: VRAM model holds 0x3C at 0x23C0 → cpu_rdata = 0x3C with cpu_done 3 cycles after cpu_req; cpu_rdata then holds 0x3C.
- Contention, guard compiled in: rendering, fetch_req held continuously, cpu_req read at 0x0010, MAX_WAIT = 4 → CPU access completes within 4 + 3 fetch slots; no fetch_valid coincides with cpu_done.
- Contention, guard compiled out: same stimulus → cpu_busy stays 1 until fetch_req drops; the CPU access then completes 3 cycles later.
- Dropped request: a second cpu_req while cpu_busy = 1 (data 0xFF) → exactly one VRAM write of the first data; one cpu_done.
